// File: rtl/jk_pkg.sv
// Shared JK excitation encoding and the helper that derives excitation from a bit transition.
package jk_pkg;

    // Excitation codes packed as {J,K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Force-style excitation that moves a bit from cur to nxt (hold when unchanged)
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        logic [1:0] e;
        if (cur == nxt) begin
            e = JK_HOLD;
        end else if (nxt) begin
            e = JK_SET;
        end else begin
            e = JK_RST;
        end
        return e;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset; no next-state logic beyond J/K.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK storage: hold / reset / set / toggle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TOG:  q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter whose state lives entirely in a bank of JK cells.
// The top computes the per-bit J/K excitation, the load clamp and the wrap/load_err pulses.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic             over_c;
    logic             wrap_c;
    logic [WIDTH-1:0] nxt_c;
    logic             tog_c;

    // Load values at or above the modulus are clamped to MOD-1
    assign over_c = (32'(load_val) >= MOD);

    // Next-count selection; tog_c marks ordinary steps that use toggle excitation
    always_comb begin
        nxt_c  = q;
        tog_c  = 1'b0;
        wrap_c = 1'b0;
        if (!load && en) begin
            if (up_dn) begin
                if (q == MAX_VAL) begin
                    nxt_c  = '0;
                    wrap_c = 1'b1;
                end else begin
                    nxt_c = q + WIDTH'(1);
                    tog_c = 1'b1;
                end
            end else begin
                if (q == '0) begin
                    nxt_c  = MAX_VAL;
                    wrap_c = 1'b1;
                end else begin
                    nxt_c = q - WIDTH'(1);
                    tog_c = 1'b1;
                end
            end
        end
    end

    // Per-bit excitation: load forces every bit, counting toggles or forces changed bits
    always_comb begin
        logic [1:0] e;
        e   = JK_HOLD;
        j_o = '0;
        k_o = '0;
        if (load) begin
            j_o = over_c ? MAX_VAL : load_val;
            k_o = ~j_o;
        end else if (en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                e = jk_excite(q[i], nxt_c[i]);
                if (tog_c && (e != JK_HOLD)) begin
                    e = JK_TOG;
                end
                j_o[i] = e[1];
                k_o[i] = e[0];
            end
        end
    end

    // Registered one-cycle status pulses, dropped by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_c;
            load_err <= load & over_c;
        end
    end

    // JK storage bank
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_o[i]),
            .k     (k_o[i]),
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and checks each cycle.
module tb_jk_mod_counter;

    logic       clk;
    logic       rst_n;
    logic       en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] q, j_o, k_o;
    logic       wrap, load_err;

    logic       en_b, up_b, load_b;
    logic [2:0] load_val_b;
    logic [2:0] q_b, j_b, k_b;
    logic       wrap_b, load_err_b;

    typedef struct {
        logic       ca;
        logic       cjk;
        logic [3:0] q;
        logic       w;
        logic       e;
        logic [3:0] j;
        logic [3:0] k;
        logic       cb;
        logic [2:0] qb;
        logic       wb;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    jk_mod_counter #(.WIDTH(4), .MOD(10)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .j_o      (j_o),
        .k_o      (k_o),
        .wrap     (wrap),
        .load_err (load_err)
    );

    jk_mod_counter #(.WIDTH(3), .MOD(8)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_b),
        .up_dn    (up_b),
        .load     (load_b),
        .load_val (load_val_b),
        .q        (q_b),
        .j_o      (j_b),
        .k_o      (k_b),
        .wrap     (wrap_b),
        .load_err (load_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on the MOD=10 counter with its expected outcome
    task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input logic [3:0] eq, input logic ew,
                       input logic ee, input logic cj, input logic [3:0] ej,
                       input logic [3:0] ek);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; up_dn = u; load = l; load_val = lv;
        en_b = 1'b0; up_b = 1'b1;
        x.ca = 1'b1; x.cjk = cj; x.q = eq; x.w = ew; x.e = ee; x.j = ej; x.k = ek;
        x.cb = 1'b0; x.qb = '0; x.wb = 1'b0;
        sb.push_back(x);
    endtask

    // One up-count cycle on the full-modulus counter
    task automatic cycb(input logic [2:0] eq, input logic ew);
        exp_t x;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; load = 1'b0;
        en_b = 1'b1; up_b = 1'b1;
        x.ca = 1'b0; x.cjk = 1'b0; x.q = '0; x.w = 1'b0; x.e = 1'b0; x.j = '0; x.k = '0;
        x.cb = 1'b1; x.qb = eq; x.wb = ew;
        sb.push_back(x);
    endtask

    // Monitor: excitation checked before the edge, registered outputs after it
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.cjk) begin
                    chk("j_o", 32'(j_o), 32'(x.j));
                    chk("k_o", 32'(k_o), 32'(x.k));
                end
                @(posedge clk);
                #1;
                if (x.ca) begin
                    chk("q", 32'(q), 32'(x.q));
                    chk("wrap", 32'(wrap), 32'(x.w));
                    chk("load_err", 32'(load_err), 32'(x.e));
                end
                if (x.cb) begin
                    chk("q_b", 32'(q_b), 32'(x.qb));
                    chk("wrap_b", 32'(wrap_b), 32'(x.wb));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; load_val_b = '0;

        // reset overrides load and en
        cyc(0, 1, 1, 1, 4'd7, 4'd0, 0, 0, 0, 4'h0, 4'h0);
        cyc(0, 1, 1, 1, 4'd7, 4'd0, 0, 0, 0, 4'h0, 4'h0);
        // release and count up through the wrap
        cyc(1, 1, 1, 0, 4'd0, 4'd1, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd2, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd3, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd4, 0, 0, 1, 4'b0111, 4'b0111);
        cyc(1, 1, 1, 0, 4'd0, 4'd5, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd6, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd7, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd8, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd0, 1, 0, 1, 4'b0000, 4'b1001);
        cyc(1, 1, 1, 0, 4'd0, 4'd1, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 1, 0, 4'd0, 4'd2, 0, 0, 0, 4'h0, 4'h0);
        // count down through the wrap
        cyc(1, 1, 0, 0, 4'd0, 4'd1, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 0, 0, 4'd0, 4'd9, 1, 0, 1, 4'b1001, 4'b0000);
        cyc(1, 1, 0, 0, 4'd0, 4'd8, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 0, 0, 4'd0, 4'd7, 0, 0, 1, 4'b1111, 4'b1111);
        // loads, clamp and load priority over counting
        cyc(1, 0, 1, 1, 4'd6,  4'd6, 0, 0, 1, 4'b0110, 4'b1001);
        cyc(1, 0, 1, 1, 4'd12, 4'd9, 0, 1, 1, 4'b1001, 4'b0110);
        cyc(1, 0, 1, 0, 4'd0,  4'd9, 0, 0, 1, 4'b0000, 4'b0000);
        cyc(1, 1, 0, 1, 4'd10, 4'd9, 0, 1, 1, 4'b1001, 4'b0110);
        cyc(1, 1, 1, 1, 4'd3,  4'd3, 0, 0, 1, 4'b0011, 4'b1100);
        cyc(1, 0, 1, 1, 4'd9,  4'd9, 0, 0, 0, 4'h0, 4'h0);
        // reset on a would-be wrap edge
        cyc(0, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 0, 1, 0, 4'd0,  4'd0, 0, 0, 1, 4'b0000, 4'b0000);
        // hold then direction changes
        cyc(1, 0, 1, 1, 4'd5,  4'd5, 0, 0, 0, 4'h0, 4'h0);
        cyc(1, 0, 1, 0, 4'd0,  4'd5, 0, 0, 1, 4'b0000, 4'b0000);
        cyc(1, 0, 0, 0, 4'd0,  4'd5, 0, 0, 1, 4'b0000, 4'b0000);
        cyc(1, 0, 1, 0, 4'd0,  4'd5, 0, 0, 1, 4'b0000, 4'b0000);
        cyc(1, 1, 1, 0, 4'd0,  4'd6, 0, 0, 1, 4'b0011, 4'b0011);
        cyc(1, 1, 0, 0, 4'd0,  4'd5, 0, 0, 1, 4'b0011, 4'b0011);
        cyc(1, 1, 1, 0, 4'd0,  4'd6, 0, 0, 0, 4'h0, 4'h0);
        // full modulus counter, WIDTH=3 MOD=8
        cycb(3'd1, 0);
        cycb(3'd2, 0);
        cycb(3'd3, 0);
        cycb(3'd4, 0);
        cycb(3'd5, 0);
        cycb(3'd6, 0);
        cycb(3'd7, 0);
        cycb(3'd0, 1);
        cycb(3'd1, 0);

        @(negedge clk);
        en = 1'b0; en_b = 1'b0; load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
